// File: rtl/compare_sequencer.sv
// compare_sequencer: magnitude comparator for two WIDTH-bit unsigned operands.
// One SLICE-bit cascadable comparator slice is reused once per clock, walking
// the captured operands from the least significant slice upwards. Because each
// higher slice overrides the cascade whenever its own slices differ, the final
// cascade value is the full-width comparison result.
module compare_sequencer #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned SLICE = 6   // WIDTH must be an integer multiple of SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gi_q, gi_d;
    logic               li_q, li_d;
    logic               ei_q, ei_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;

    logic [SLICE-1:0]   a_sl, b_sl;
    logic               gto, lto, eqo;

    // Select the operand slice addressed by the running index.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = a_q[i*SLICE +: SLICE];
                b_sl = b_q[i*SLICE +: SLICE];
            end
        end
    end

    // Cascadable slice comparator: a tie in this slice defers to lower slices.
    always_comb begin
        gto = (a_sl > b_sl) | ((a_sl == b_sl) & gi_q);
        lto = (a_sl < b_sl) | ((a_sl == b_sl) & li_q);
        eqo = (a_sl == b_sl) & ei_q;
    end

    // Next-state and output decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gi_d    = gi_q;
        li_d    = li_q;
        ei_d    = ei_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    gi_d    = 1'b0;
                    li_d    = 1'b0;
                    ei_d    = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // start is deliberately not looked at here: a running
                // comparison cannot be restarted or have its operands replaced.
                gi_d = gto;
                li_d = lto;
                ei_d = eqo;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    gt_d    = gto;
                    lt_d    = lto;
                    eq_d    = eqo;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of every stored bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gi_q    <= 1'b0;
            li_q    <= 1'b0;
            ei_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            gi_q    <= gi_d;
            li_q    <= li_d;
            ei_q    <= ei_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Directed self-checking bench for compare_sequencer (default 24/6 geometry).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_compare_sequencer;

    localparam int unsigned WIDTH  = 24;
    localparam int unsigned SLICE  = 6;
    localparam int unsigned NSLICE = WIDTH / SLICE;

    localparam logic [2:0] R_NONE = 3'b000;   // {gt, lt, eq}
    localparam logic [2:0] R_GT   = 3'b100;
    localparam logic [2:0] R_LT   = 3'b010;
    localparam logic [2:0] R_EQ   = 3'b001;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] prev_res;   // result the outputs must hold until the next done

    compare_sequencer #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .gt   (gt),
        .lt   (lt),
        .eq   (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full comparison with start pulsed for a single cycle.
    task automatic run_compare(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [2:0] exp);
        @(negedge clk);
        A     = a;
        B     = b;
        start = 1'b1;
        for (int c = 1; c <= NSLICE; c++) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, " busy in run"}, 32'(busy), 32'd1);
            check({tag, " done in run"}, 32'(done), 32'd0);
            check({tag, " flags held"}, 32'({gt, lt, eq}), 32'(prev_res));
        end
        @(negedge clk);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " done pulse"}, 32'(done), 32'd1);
        check({tag, " result"}, 32'({gt, lt, eq}), 32'(exp));
        @(negedge clk);
        check({tag, " done width"}, 32'(done), 32'd0);
        check({tag, " result kept"}, 32'({gt, lt, eq}), 32'(exp));
        prev_res = exp;
    endtask

    initial begin
        int done_cnt;
        int done_cyc;

        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        prev_res = R_NONE;

        // Reset state, both during and after reset.
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst flags", 32'({gt, lt, eq}), 32'(R_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle flags", 32'({gt, lt, eq}), 32'(R_NONE));

        // Basic compares, including MSB-decided and LSB-decided boundaries.
        run_compare("45<57", 24'd45, 24'd57, R_LT);
        run_compare("equal", 24'hABCDEF, 24'hABCDEF, R_EQ);
        run_compare("msb gt", 24'h800000, 24'h7FFFFF, R_GT);
        run_compare("lsb gt", 24'h000001, 24'h000000, R_GT);
        run_compare("lsb lt", 24'h000000, 24'h000001, R_LT);
        run_compare("msb lt", 24'h7FFFFF, 24'h800000, R_LT);

        // start re-pulsed during RUN with new operands must be ignored.
        @(negedge clk);
        A        = 24'd10;
        B        = 24'd20;
        start    = 1'b1;
        done_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
                check("restart result", 32'({gt, lt, eq}), 32'(R_LT));
            end
            if (c == 1) start = 1'b0;
            if (c == 2) begin
                A     = 24'd99;
                B     = 24'd1;
                start = 1'b1;
            end
            if (c == 3) start = 1'b0;
        end
        check("restart done count", 32'(done_cnt), 32'd1);
        check("restart done latency", 32'(done_cyc), 32'(NSLICE + 1));
        prev_res = R_LT;

        // Reset in the middle of a RUN: immediate clear, no done pulse.
        @(negedge clk);
        A     = 24'd3;
        B     = 24'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst busy before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst flags", 32'({gt, lt, eq}), 32'(R_NONE));
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst no done", 32'(done_cnt), 32'd0);
        check("midrst idle flags", 32'({gt, lt, eq}), 32'(R_NONE));
        prev_res = R_NONE;
        run_compare("57>45", 24'd57, 24'd45, R_GT);

        // Back-to-back: start held through DONE launches a second RUN there.
        @(negedge clk);
        A     = 24'd1;
        B     = 24'd2;
        start = 1'b1;
        for (int c = 1; c <= 2 * NSLICE + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                A = 24'd7;   // must not disturb the first comparison
                B = 24'd7;
            end
            if (c <= NSLICE) begin
                check("b2b first busy", 32'(busy), 32'd1);
                check("b2b first flags held", 32'({gt, lt, eq}), 32'(R_GT));
            end else if (c == NSLICE + 1) begin
                check("b2b first done", 32'(done), 32'd1);
                check("b2b first result", 32'({gt, lt, eq}), 32'(R_LT));
            end else if (c <= 2 * NSLICE + 1) begin
                if (c == NSLICE + 2) start = 1'b0;
                check("b2b second busy", 32'(busy), 32'd1);
                check("b2b second no done", 32'(done), 32'd0);
                check("b2b second flags held", 32'({gt, lt, eq}), 32'(R_LT));
            end else if (c == 2 * NSLICE + 2) begin
                check("b2b second done", 32'(done), 32'd1);
                check("b2b second result", 32'({gt, lt, eq}), 32'(R_EQ));
            end else begin
                check("b2b second done width", 32'(done), 32'd0);
                check("b2b final busy", 32'(busy), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compare_sequencer.md
COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 6, meaning width of the shared comparator slice; WIDTH SHALL be an integer multiple of SLICE, with NSLICE = WIDTH/SLICE.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to compare A and B.
REQ-006 The block SHALL have port A, input, WIDTH bits: unsigned operand A.
REQ-007 The block SHALL have port B, input, WIDTH bits: unsigned operand B.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a comparison is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-010 The block SHALL have port gt, output, 1 bit: result flag for A > B.
REQ-011 The block SHALL have port lt, output, 1 bit: result flag for A < B.
REQ-012 The block SHALL have port eq, output, 1 bit: result flag for A == B.

Function
REQ-013 The block SHALL compare A and B using one SLICE-bit cascadable comparator slice, reused once per cycle, processing slices LSB-first (slice 0 = bits SLICE-1:0).
REQ-014 Slice rule, for slice operands a and b with cascade inputs gi, li, ei:
- gto = (a>b) | (a==b & gi)
- lto = (a<b) | (a==b & li)
- eqo = (a==b) & ei
REQ-015 The block SHALL implement FSM states IDLE, RUN, and DONE; the state after reset SHALL be IDLE.
REQ-016 IDLE/DONE with start=1 at an edge (edge 0) SHALL cause the following actions, and the next state SHALL be RUN:
- capture A and B into internal registers;
- set cascade registers to gi=0, li=0, ei=1;
- clear slice index to 0;
- set busy=1.
REQ-017 RUN: at each edge the block SHALL evaluate slice[index] of the captured operands with the cascade registers, store gto/lto/eqo back into the cascade registers, and increment index.
REQ-018 RUN SHALL last exactly NSLICE edges (edges 1..NSLICE); at edge NSLICE the cascade result SHALL be copied to gt/lt/eq, busy SHALL drop to 0, done SHALL rise to 1, and the next state SHALL be DONE.
REQ-019 DONE with start=0 at the next edge SHALL return to IDLE with done=0; done SHALL therefore be exactly one cycle wide.
REQ-020 Start-to-done latency SHALL be NSLICE+1 edges (5 edges for the defaults).
REQ-021 start while in RUN SHALL be ignored; captured operands SHALL be unaffected.
REQ-022 A and B changing after edge 0 SHALL NOT affect the result in progress.
REQ-023 gt/lt/eq SHALL hold the last completed result through IDLE and the whole of any later RUN, changing only at the final RUN edge; exactly one of them SHALL be 1 after any completed comparison.
REQ-024 A start accepted in DONE SHALL deassert done at that same edge and begin a new RUN.
REQ-025 The slice index SHALL be ceil(log2(NSLICE)) bits wide, or 1 bit if NSLICE=1, and SHALL never exceed NSLICE-1 in RUN.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE and index=0;
- busy=0, done=0;
- gt=0, lt=0, eq=0;
- captured operand and cascade registers to 0.
REQ-027 Reset asserted mid-RUN SHALL abort the comparison with no done pulse; the first start after rst_n rises SHALL behave as in REQ-016.

Verification
REQ-028 The bench SHALL check A=45, B=57, start pulse -> busy=1 for 4 cycles, then done=1 with lt=1, gt=0, eq=0 after the 5th edge.
REQ-029 The bench SHALL check A=B=24'hABCDEF -> eq=1, gt=0, lt=0 with the done pulse.
REQ-030 The bench SHALL check A=24'h800000, B=24'h7FFFFF -> gt=1 (the MSB slice overrides lower slices); then A=24'h000001, B=24'h000000 -> gt=1 (decided by the LSB slice only).
REQ-031 The bench SHALL check start re-pulsed at cycle 2 of RUN with different A/B -> that start is ignored, the original result is delivered, and only one done pulse occurs.
REQ-032 The bench SHALL check rst_n pulsed low during RUN -> all outputs 0 immediately, no done pulse, and a subsequent A=57, B=45 compare gives gt=1.
REQ-033 The bench SHALL check back-to-back starts, with start held high through DONE -> a second RUN begins at the DONE edge, and gt/lt/eq hold the first result until the second done.
